// File: rtl/iir_channel_scheduler_if.sv
// rtl/iir_channel_scheduler_if.sv - sample request and filter result bundle for iir_channel_scheduler
interface iir_channel_scheduler_if #(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
);
  logic [NCH-1:0]   req;
  logic [4*NCH-1:0] x_in;
  logic [NCH-1:0]   ack;
  logic             out_valid;
  logic [CW-1:0]    out_ch;
  logic [7:0]       out_y;

  modport master (output req, x_in, input ack, out_valid, out_ch, out_y);
  modport slave  (input req, x_in, output ack, out_valid, out_ch, out_y);
endinterface

// File: rtl/iir_channel_scheduler.sv
// rtl/iir_channel_scheduler.sv - one first-order IIR datapath shared round-robin across NCH channels
module iir_channel_scheduler #(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  iir_channel_scheduler_if.slave bus,
  input  logic [NCH-1:0]        ch_clr,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_b0,
  input  logic [3:0]            cfg_b1,
  input  logic [3:0]            cfg_a1,
  output logic                  cfg_pending,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  grant_q, grant_d;
  logic [CW-1:0]  last_grant_q, last_grant_d;
  logic [3:0]     x_q, x_d;
  logic [3:0]     xp_op_q, xp_op_d;
  logic [7:0]     yp_op_q, yp_op_d;
  logic [3:0]     x_prev_q [NCH];
  logic [3:0]     x_prev_d [NCH];
  logic [7:0]     y_prev_q [NCH];
  logic [7:0]     y_prev_d [NCH];
  logic [3:0]     b0_q, b0_d, b1_q, b1_d, a1_q, a1_d;
  logic [3:0]     sb0_q, sb0_d, sb1_q, sb1_d, sa1_q, sa1_d;
  logic           cfg_pending_q, cfg_pending_d;
  logic [NCH-1:0] ack_q, ack_d;
  logic           out_valid_q, out_valid_d;
  logic [CW-1:0]  out_ch_q, out_ch_d;
  logic [7:0]     out_y_q, out_y_d;

  logic [CW-1:0]      winner;
  logic signed [7:0]  prod_b0, prod_b1;
  logic signed [11:0] prod_a1;
  logic [7:0]         y_calc;

  // Round-robin: scan from the channel after the last grant, wrapping at NCH.
  always_comb begin
    logic          found;
    logic [CW-1:0] idx;
    winner = last_grant_q;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = CW'((int'(last_grant_q) + i) % NCH);
      if (!found && bus.req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // a1 is Q0.4, so the feedback term is the product floored by 16.
  always_comb begin
    prod_b0 = $signed({{4{b0_q[3]}}, b0_q}) * $signed({{4{x_q[3]}}, x_q});
    prod_b1 = $signed({{4{b1_q[3]}}, b1_q}) * $signed({{4{xp_op_q[3]}}, xp_op_q});
    prod_a1 = $signed({{8{a1_q[3]}}, a1_q}) * $signed({{4{yp_op_q[7]}}, yp_op_q});
    y_calc  = prod_b0 + prod_b1 + 8'(prod_a1 >>> 4);
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    x_d           = x_q;
    xp_op_d       = xp_op_q;
    yp_op_d       = yp_op_q;
    x_prev_d      = x_prev_q;
    y_prev_d      = y_prev_q;
    b0_d          = b0_q;
    b1_d          = b1_q;
    a1_d          = a1_q;
    sb0_d         = sb0_q;
    sb1_d         = sb1_q;
    sa1_d         = sa1_q;
    cfg_pending_d = cfg_pending_q;
    ack_d         = '0;
    out_valid_d   = 1'b0;
    out_ch_d      = out_ch_q;
    out_y_d       = out_y_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_pending_q) begin
          b0_d          = sb0_q;
          b1_d          = sb1_q;
          a1_d          = sa1_q;
          cfg_pending_d = 1'b0;
        end
        if (|bus.req) begin
          grant_d       = winner;
          last_grant_d  = winner;
          x_d           = bus.x_in[int'(winner)*4 +: 4];
          ack_d[winner] = 1'b1;
          state_d       = S_LOAD;
        end
      end
      S_LOAD: begin
        xp_op_d = x_prev_q[grant_q];
        yp_op_d = y_prev_q[grant_q];
        state_d = S_CALC;
      end
      S_CALC: begin
        out_y_d           = y_calc;
        out_ch_d          = grant_q;
        out_valid_d       = 1'b1;
        x_prev_d[grant_q] = x_q;
        y_prev_d[grant_q] = y_calc;
        state_d           = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Shadow write lands after any commit above, so it stays pending.
    if (cfg_we) begin
      sb0_d         = cfg_b0;
      sb1_d         = cfg_b1;
      sa1_d         = cfg_a1;
      cfg_pending_d = 1'b1;
    end

    for (int i = 0; i < NCH; i++) begin
      if (ch_clr[i]) begin
        x_prev_d[i] = '0;
        y_prev_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      last_grant_q  <= CW'(NCH - 1);
      x_q           <= '0;
      xp_op_q       <= '0;
      yp_op_q       <= '0;
      for (int i = 0; i < NCH; i++) begin
        x_prev_q[i] <= '0;
        y_prev_q[i] <= '0;
      end
      b0_q          <= '0;
      b1_q          <= '0;
      a1_q          <= '0;
      sb0_q         <= '0;
      sb1_q         <= '0;
      sa1_q         <= '0;
      cfg_pending_q <= 1'b0;
      ack_q         <= '0;
      out_valid_q   <= 1'b0;
      out_ch_q      <= '0;
      out_y_q       <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      x_q           <= x_d;
      xp_op_q       <= xp_op_d;
      yp_op_q       <= yp_op_d;
      x_prev_q      <= x_prev_d;
      y_prev_q      <= y_prev_d;
      b0_q          <= b0_d;
      b1_q          <= b1_d;
      a1_q          <= a1_d;
      sb0_q         <= sb0_d;
      sb1_q         <= sb1_d;
      sa1_q         <= sa1_d;
      cfg_pending_q <= cfg_pending_d;
      ack_q         <= ack_d;
      out_valid_q   <= out_valid_d;
      out_ch_q      <= out_ch_d;
      out_y_q       <= out_y_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_y     = out_y_q;
  assign cfg_pending   = cfg_pending_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_iir_channel_scheduler.sv
// tb/tb_iir_channel_scheduler.sv - directed self-checking bench for iir_channel_scheduler
module tb_iir_channel_scheduler;
  localparam int NCH = 4;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [NCH-1:0] ch_clr = '0;
  logic           cfg_we = 1'b0;
  logic [3:0]     cfg_b0 = '0, cfg_b1 = '0, cfg_a1 = '0;
  logic           cfg_pending, busy;
  int             n_vec = 0;
  int             n_err = 0;

  iir_channel_scheduler_if #(.NCH(NCH)) bus ();

  iir_channel_scheduler #(.NCH(NCH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .ch_clr      (ch_clr),
    .cfg_we      (cfg_we),
    .cfg_b0      (cfg_b0),
    .cfg_b1      (cfg_b1),
    .cfg_a1      (cfg_a1),
    .cfg_pending (cfg_pending),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic set_cfg(input logic [3:0] b0, input logic [3:0] b1, input logic [3:0] a1);
    @(negedge clk); cfg_b0 = b0; cfg_b1 = b1; cfg_a1 = a1; cfg_we = 1'b1;
    @(negedge clk); cfg_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic clr(input logic [NCH-1:0] m);
    @(negedge clk); ch_clr = m;
    @(negedge clk); ch_clr = '0;
  endtask

  task automatic do_sample(input int ch, input logic [3:0] x, output logic [NCH-1:0] ack_seen,
                           output logic busy_seen, output logic [7:0] y, output logic [CW-1:0] ch_seen,
                           output int lat);
    @(negedge clk); bus.req = '0; bus.req[ch] = 1'b1; bus.x_in[ch*4 +: 4] = x;
    @(negedge clk); ack_seen = bus.ack; busy_seen = busy; bus.req = '0;
    lat = 0;
    while (!bus.out_valid && lat < 10) begin @(negedge clk); lat++; end
    y = bus.out_y; ch_seen = bus.out_ch;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; bus.req = '0; bus.x_in = '0;
    repeat (3) @(negedge clk);
    n_vec++; if (bus.ack !== 4'b0000) begin n_err++; $display("FAIL rst_ack: got %b want 0000", bus.ack); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.out_ch !== 2'd0) begin n_err++; $display("FAIL rst_out_ch: got %0d want 0", bus.out_ch); end
    n_vec++; if (bus.out_y !== 8'h00) begin n_err++; $display("FAIL rst_out_y: got %h want 00", bus.out_y); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (cfg_pending !== 1'b0) begin n_err++; $display("FAIL rst_cfg_pending: got %b want 0", cfg_pending); end
    reset_n = 1'b1;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int ack_ch [4];
    int ack_cyc [4];
    int ov_cyc [4];
    logic [7:0] ov_y [4];
    logic [CW-1:0] ov_ch [4];
    int na, nv;
    na = 0; nv = 0;
    for (int n = 0; n < 4; n++) begin ack_ch[n] = -1; ack_cyc[n] = -1; ov_cyc[n] = -1; ov_y[n] = 'x; ov_ch[n] = 'x; end
    set_cfg(4'd1, 4'd0, 4'd0);
    @(negedge clk); bus.x_in = {4'd4, 4'd3, 4'd2, 4'd1}; bus.req = 4'hF;
    for (int c = 1; c <= 40 && nv < 4; c++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        if (na < 4) begin
          for (int j = 0; j < NCH; j++) if (bus.ack[j]) ack_ch[na] = j;
          ack_cyc[na] = c;
        end
        na++;
        bus.req = bus.req & ~bus.ack;
      end
      if (bus.out_valid) begin
        if (nv < 4) begin ov_cyc[nv] = c; ov_y[nv] = bus.out_y; ov_ch[nv] = bus.out_ch; end
        nv++;
      end
    end
    bus.req = '0; bus.x_in = '0;
    n_vec++; if (na !== 4) begin n_err++; $display("FAIL rr_ack_count: got %0d want 4", na); end
    n_vec++; if (nv !== 4) begin n_err++; $display("FAIL rr_valid_count: got %0d want 4", nv); end
    for (int n = 0; n < 4; n++) begin
      n_vec++; if (ack_ch[n] !== n) begin n_err++; $display("FAIL rr_grant%0d: got %0d want %0d", n, ack_ch[n], n); end
      n_vec++; if (ack_cyc[n] !== 1 + 4*n) begin n_err++; $display("FAIL rr_ack_cyc%0d: got %0d want %0d", n, ack_cyc[n], 1 + 4*n); end
      n_vec++; if (ov_cyc[n] !== 3 + 4*n) begin n_err++; $display("FAIL rr_valid_cyc%0d: got %0d want %0d", n, ov_cyc[n], 3 + 4*n); end
      n_vec++; if (ov_ch[n] !== CW'(n)) begin n_err++; $display("FAIL rr_out_ch%0d: got %0d want %0d", n, ov_ch[n], n); end
      n_vec++; if (ov_y[n] !== 8'(n + 1)) begin n_err++; $display("FAIL rr_out_y%0d: got %h want %h", n, ov_y[n], 8'(n + 1)); end
    end
  endtask

  task automatic test_passthrough();
    logic [NCH-1:0] a; logic b; logic [7:0] y; logic [CW-1:0] ch; int lat;
    set_cfg(4'd1, 4'd0, 4'd0);
    do_sample(0, 4'd5, a, b, y, ch, lat);
    n_vec++; if (a !== 4'b0001) begin n_err++; $display("FAIL pt_ack: got %b want 0001", a); end
    n_vec++; if (b !== 1'b1) begin n_err++; $display("FAIL pt_busy: got %b want 1", b); end
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL pt_latency: got %0d want 2", lat); end
    n_vec++; if (y !== 8'h05) begin n_err++; $display("FAIL pt_out_y: got %h want 05", y); end
    n_vec++; if (ch !== 2'd0) begin n_err++; $display("FAIL pt_out_ch: got %0d want 0", ch); end
  endtask

  task automatic test_decay();
    logic [3:0] xs [4] = '{4'd7, 4'd0, 4'd0, 4'd0};
    logic [7:0] ex [4] = '{8'd49, 8'd21, 8'd9, 8'd3};
    logic [NCH-1:0] a; logic b; logic [7:0] y; logic [CW-1:0] ch; int lat;
    clr(4'b0010);
    set_cfg(4'd7, 4'd0, 4'd7);
    for (int n = 0; n < 4; n++) begin
      do_sample(1, xs[n], a, b, y, ch, lat);
      n_vec++; if (y !== ex[n]) begin n_err++; $display("FAIL decay_y%0d: got %0d want %0d", n, y, ex[n]); end
      n_vec++; if (ch !== 2'd1) begin n_err++; $display("FAIL decay_ch%0d: got %0d want 1", n, ch); end
    end
  endtask

  task automatic test_neg_feedback();
    logic [7:0] ex [4] = '{8'hFD, 8'h01, 8'hFF, 8'h00};
    logic [NCH-1:0] a; logic b; logic [7:0] y; logic [CW-1:0] ch; int lat;
    clr(4'b1000);
    set_cfg(4'd2, 4'd0, 4'd0);
    do_sample(3, 4'd3, a, b, y, ch, lat);
    n_vec++; if (y !== 8'h06) begin n_err++; $display("FAIL negfb_seed: got %h want 06", y); end
    set_cfg(4'd0, 4'd0, 4'h8);
    for (int n = 0; n < 4; n++) begin
      do_sample(3, 4'd0, a, b, y, ch, lat);
      n_vec++; if (y !== ex[n]) begin n_err++; $display("FAIL negfb_y%0d: got %h want %h", n, y, ex[n]); end
    end
  endtask

  task automatic test_wrap();
    logic [NCH-1:0] a; logic b; logic [7:0] y; logic [CW-1:0] ch; int lat;
    clr(4'b0100);
    set_cfg(4'h8, 4'h8, 4'd0);
    do_sample(2, 4'h8, a, b, y, ch, lat);
    n_vec++; if (y !== 8'h40) begin n_err++; $display("FAIL wrap_first: got %h want 40", y); end
    do_sample(2, 4'h8, a, b, y, ch, lat);
    n_vec++; if (y !== 8'h80) begin n_err++; $display("FAIL wrap_second: got %h want 80", y); end
    n_vec++; if (ch !== 2'd2) begin n_err++; $display("FAIL wrap_ch: got %0d want 2", ch); end
  endtask

  task automatic test_interleave();
    int         chs [4] = '{0, 1, 0, 1};
    logic [3:0] xs [4]  = '{4'd2, 4'hF, 4'd3, 4'd5};
    logic [7:0] ex [4]  = '{8'h02, 8'hFF, 8'h07, 8'h02};
    logic [NCH-1:0] a; logic b; logic [7:0] y; logic [CW-1:0] ch; int lat;
    clr(4'b0011);
    set_cfg(4'd1, 4'd2, 4'd4);
    for (int n = 0; n < 4; n++) begin
      do_sample(chs[n], xs[n], a, b, y, ch, lat);
      n_vec++; if (y !== ex[n]) begin n_err++; $display("FAIL ilv_y%0d: got %h want %h", n, y, ex[n]); end
      n_vec++; if (ch !== CW'(chs[n])) begin n_err++; $display("FAIL ilv_ch%0d: got %0d want %0d", n, ch, chs[n]); end
    end
  endtask

  task automatic test_cfg_inflight();
    logic [NCH-1:0] a; logic b; logic [7:0] y; logic [CW-1:0] ch; int lat;
    clr(4'b0100);
    @(negedge clk); bus.req = 4'b0100; bus.x_in[11:8] = 4'd3;
    @(negedge clk);
    n_vec++; if (bus.ack !== 4'b0100) begin n_err++; $display("FAIL cfgf_ack: got %b want 0100", bus.ack); end
    bus.req = '0;
    @(negedge clk); cfg_b0 = 4'd2; cfg_b1 = 4'd0; cfg_a1 = 4'd0; cfg_we = 1'b1;
    @(negedge clk); cfg_we = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL cfgf_valid: got %b want 1", bus.out_valid); end
    n_vec++; if (bus.out_y !== 8'h03) begin n_err++; $display("FAIL cfgf_old_coef: got %h want 03", bus.out_y); end
    n_vec++; if (cfg_pending !== 1'b1) begin n_err++; $display("FAIL cfgf_pend_done: got %b want 1", cfg_pending); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL cfgf_idle: got %b want 0", busy); end
    n_vec++; if (cfg_pending !== 1'b1) begin n_err++; $display("FAIL cfgf_pend_idle: got %b want 1", cfg_pending); end
    @(negedge clk);
    n_vec++; if (cfg_pending !== 1'b0) begin n_err++; $display("FAIL cfgf_commit: got %b want 0", cfg_pending); end
    do_sample(2, 4'd1, a, b, y, ch, lat);
    n_vec++; if (y !== 8'h02) begin n_err++; $display("FAIL cfgf_new_coef: got %h want 02", y); end
  endtask

  task automatic test_cfg_commit();
    logic [NCH-1:0] a; logic b; logic [7:0] y; logic [CW-1:0] ch; int lat;
    clr(4'b1000);
    @(negedge clk); cfg_b0 = 4'd3; cfg_b1 = 4'd0; cfg_a1 = 4'd0; cfg_we = 1'b1;
    @(negedge clk);
    n_vec++; if (cfg_pending !== 1'b1) begin n_err++; $display("FAIL cmt_pend_a: got %b want 1", cfg_pending); end
    cfg_b0 = 4'd1; bus.req = 4'b1000; bus.x_in[15:12] = 4'd2;
    @(negedge clk); cfg_we = 1'b0; bus.req = '0;
    n_vec++; if (cfg_pending !== 1'b1) begin n_err++; $display("FAIL cmt_pend_b: got %b want 1", cfg_pending); end
    n_vec++; if (bus.ack !== 4'b1000) begin n_err++; $display("FAIL cmt_ack: got %b want 1000", bus.ack); end
    lat = 0;
    while (!bus.out_valid && lat < 10) begin @(negedge clk); lat++; end
    n_vec++; if (bus.out_y !== 8'h06) begin n_err++; $display("FAIL cmt_launch_coef: got %h want 06", bus.out_y); end
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (cfg_pending !== 1'b0) begin n_err++; $display("FAIL cmt_pend_clear: got %b want 0", cfg_pending); end
    do_sample(3, 4'd1, a, b, y, ch, lat);
    n_vec++; if (y !== 8'h01) begin n_err++; $display("FAIL cmt_last_write: got %h want 01", y); end
  endtask

  task automatic test_clear_vs_write();
    logic [NCH-1:0] a; logic b; logic [7:0] y; logic [CW-1:0] ch; int lat;
    set_cfg(4'd1, 4'd1, 4'd7);
    @(negedge clk); bus.req = 4'b0010; bus.x_in[7:4] = 4'd5;
    @(negedge clk); bus.req = '0;
    @(negedge clk); ch_clr = 4'b0010;
    @(negedge clk); ch_clr = '0;
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL clr_valid: got %b want 1", bus.out_valid); end
    n_vec++; if (bus.out_y !== 8'h0A) begin n_err++; $display("FAIL clr_result: got %h want 0a", bus.out_y); end
    @(negedge clk);
    do_sample(1, 4'd2, a, b, y, ch, lat);
    n_vec++; if (y !== 8'h02) begin n_err++; $display("FAIL clr_wins: got %h want 02", y); end
  endtask

  task automatic test_reset_midop();
    logic [NCH-1:0] a; logic b; logic [7:0] y; logic [CW-1:0] ch; int lat; int seen;
    set_cfg(4'd1, 4'd0, 4'd0);
    @(negedge clk); bus.req = 4'b0001; bus.x_in[3:0] = 4'd5;
    @(negedge clk); bus.req = '0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_load: got %b want 1", busy); end
    reset_n = 1'b0;
    #1;
    n_vec++; if (bus.ack !== 4'b0000) begin n_err++; $display("FAIL rmid_ack: got %b want 0000", bus.ack); end
    n_vec++; if (bus.out_y !== 8'h00) begin n_err++; $display("FAIL rmid_out_y: got %h want 00", bus.out_y); end
    n_vec++; if (bus.out_ch !== 2'd0) begin n_err++; $display("FAIL rmid_out_ch: got %0d want 0", bus.out_ch); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", busy); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (6) begin @(negedge clk); if (bus.out_valid) seen++; end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL rmid_no_valid: got %0d want 0", seen); end
    do_sample(0, 4'd5, a, b, y, ch, lat);
    n_vec++; if (a !== 4'b0001) begin n_err++; $display("FAIL rmid_first_grant: got %b want 0001", a); end
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL rmid_latency: got %0d want 2", lat); end
    n_vec++; if (y !== 8'h00) begin n_err++; $display("FAIL rmid_zero_coef: got %h want 00", y); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_passthrough();
    test_decay();
    test_neg_feedback();
    test_wrap();
    test_interleave();
    test_cfg_inflight();
    test_cfg_commit();
    test_clear_vs_write();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
